hamming_encode_arbiter: RTL

Round-robin arbiter that shares one 8→12-bit Hamming encoder between up to four byte requesters, such as the global-register readback, service-record and header paths of the emulator. It accepts one byte per cycle from the winning requester, encodes it and holds the 12-bit word with its source index in an output register. Downstream consumers take the word through a valid/ready handshake. The block sits between the requesting state machines and the serializer feed.

---
 rtl/hamming_encode_arbiter_if.sv | 26 ++
 rtl/hamming_encode_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/hamming_encode_arbiter_if.sv
// Bus bundle between byte requesters, the shared Hamming encoder arbiter and
// the downstream consumer. The arbiter uses the slave modport.
interface hamming_encode_arbiter_if #(
  parameter int SRC_W = 2
);
  localparam int N_REQ = 1 << SRC_W;

  logic [N_REQ-1:0]   Req;
  logic [8*N_REQ-1:0] Req_Data;
  logic [N_REQ-1:0]   Gnt;
  logic               Out_Valid;
  logic [11:0]        Out_Data;
  logic [SRC_W-1:0]   Out_Src;
  logic               Out_Ready;
  logic               Busy;

  modport master (
    output Req, Req_Data, Out_Ready,
    input  Gnt, Out_Valid, Out_Data, Out_Src, Busy
  );

  modport slave (
    input  Req, Req_Data, Out_Ready,
    output Gnt, Out_Valid, Out_Data, Out_Src, Busy
  );
endinterface

// File: rtl/hamming_encode_arbiter.sv
// Shares one 8->12 bit Hamming encoder between 2**SRC_W byte requesters.
// Define HAMMING_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module hamming_encode_arbiter #(
  parameter int SRC_W = 2
) (
  input logic                    Clk,
  input logic                    Reset_B,
  hamming_encode_arbiter_if.slave bus
);
  localparam int N_REQ = 1 << SRC_W;

  function automatic logic [11:0] hamming_enc(input logic [7:0] d);
    logic p1, p2, p3, p4;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p3 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p4 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7], d[6], d[5], d[4], p4, d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  logic [SRC_W-1:0] base;
  logic [SRC_W-1:0] idx;
  logic [SRC_W-1:0] win_idx;
  logic             win_found;
  logic             accept;
  logic [7:0]       win_byte;

  logic             out_valid_q, out_valid_d;
  logic [11:0]      out_data_q,  out_data_d;
  logic [SRC_W-1:0] out_src_q,   out_src_d;
`ifdef HAMMING_ARB_RR_EN
  logic [SRC_W-1:0] ptr_q, ptr_d;
`endif

  // Winner search starts at the round-robin pointer (or index 0) and wraps
  // through the natural SRC_W-bit overflow of the index addition.
  always_comb begin : winner_search
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
`ifdef HAMMING_ARB_RR_EN
    base = ptr_q;
`else
    base = '0;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      idx = base + SRC_W'(k);
      if (!win_found && bus.Req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Gnt is forced low while reset is asserted so the bus shows its reset state.
  assign accept   = Reset_B & win_found & (~out_valid_q | bus.Out_Ready);
  assign win_byte = bus.Req_Data[{win_idx, 3'b000} +: 8];
  assign bus.Gnt  = accept ? (N_REQ'(1) << win_idx) : '0;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = hamming_enc(win_byte);
      out_src_d   = win_idx;
    end else if (out_valid_q && bus.Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef HAMMING_ARB_RR_EN
  assign ptr_d = accept ? (win_idx + SRC_W'(1)) : ptr_q;
`endif

  // NOTE: data and source flops are reset too, since they are visible on the bus.
  always_ff @(posedge Clk or negedge Reset_B) begin
    if (!Reset_B) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
`ifdef HAMMING_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
`ifdef HAMMING_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Src   = out_src_q;
  assign bus.Busy      = out_valid_q | (|bus.Req);

endmodule
